axi_clock_converter_drain_ctrl: RTL and testbench

Single-clock sequencing controller that sits on the slave-side AW/AR/B/R handshakes in front of an AXI clock converter. It tracks outstanding write and read transactions and throttles new requests at a configurable limit. On request it drains the converter and pulses the converter's reset. It also provides the converter's reset sequence after system reset. Payload signals bypass the block; only valid/ready/last pass through it.

---
 rtl/axi_clock_converter_drain_ctrl.sv | 174 +++++++++++++++++
 tb/tb_axi_clock_converter_drain_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_clock_converter_drain_ctrl.sv
// AXI clock-converter drain/reset sequencer: outstanding tracking, AW/AR gating,
// drain handshake and converter reset pulse. Optional drain timeout: AXI_DRAIN_TIMEOUT_EN.
module axi_clock_converter_drain_ctrl #(
    parameter int MAX_OUTSTANDING = 16,
    parameter int RESET_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES  = 1024,
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             s_axi_awvalid,
    output logic             s_axi_awready,
    output logic             m_axi_awvalid,
    input  logic             m_axi_awready,
    input  logic             s_axi_arvalid,
    output logic             s_axi_arready,
    output logic             m_axi_arvalid,
    input  logic             m_axi_arready,
    input  logic             bvalid_i,
    input  logic             bready_i,
    input  logic             rvalid_i,
    input  logic             rready_i,
    input  logic             rlast_i,
    input  logic             drain_req_i,
    output logic             drain_ack_o,
    output logic             conv_reset_no,
    output logic [CNT_W-1:0] wr_outstanding_o,
    output logic [CNT_W-1:0] rd_outstanding_o,
    output logic             timeout_o
);

    localparam int RST_W = $clog2(RESET_CYCLES);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        CONV_RST,
        RUN,
        DRAIN,
        DONE
    } state_e;

    state_e state_q, state_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic from_drain_q, from_drain_d;
    logic aw_pend_q, aw_pend_d;
    logic ar_pend_q, ar_pend_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

    logic open_aw, open_ar;
    logic aw_hs, ar_hs, b_dec, r_dec;
    logic drained, tmo_force, clr;

    assign drained = (wr_cnt_q == '0) && (rd_cnt_q == '0)
                     && !aw_pend_q && !ar_pend_q;

`ifdef AXI_DRAIN_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic timeout_q, timeout_d;

    assign tmo_force = (state_q == DRAIN) && !drained
                       && (tmo_cnt_q == TMO_LAST);
    assign tmo_cnt_d = (state_q == DRAIN) ? tmo_cnt_q + TMO_W'(1) : '0;
    assign timeout_d = timeout_q | tmo_force;
    assign timeout_o = timeout_q;

    // Drain watchdog: counts DRAIN cycles, sticky flag until system reset
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign tmo_force = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Next state, reset-pulse timing and AW/AR gate openings
    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        from_drain_d = from_drain_q;
        open_aw      = 1'b0;
        open_ar      = 1'b0;
        unique case (state_q)
            CONV_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    rst_cnt_d    = '0;
                    from_drain_d = 1'b0;
                    state_d      = from_drain_q ? DONE : RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            RUN: begin
                open_aw = aw_pend_q || (wr_cnt_q < MAX_C);
                open_ar = ar_pend_q || (rd_cnt_q < MAX_C);
                if (drain_req_i) state_d = DRAIN;
            end
            DRAIN: begin
                open_aw = aw_pend_q;
                open_ar = ar_pend_q;
                if (drained || tmo_force) begin
                    state_d      = CONV_RST;
                    from_drain_d = 1'b1;
                end
            end
            DONE: begin
                if (!drain_req_i) state_d = RUN;
            end
            default: state_d = CONV_RST;
        endcase
    end

    assign m_axi_awvalid = s_axi_awvalid & open_aw;
    assign s_axi_awready = m_axi_awready & open_aw;
    assign m_axi_arvalid = s_axi_arvalid & open_ar;
    assign s_axi_arready = m_axi_arready & open_ar;

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign ar_hs = m_axi_arvalid & m_axi_arready;
    assign b_dec = bvalid_i & bready_i & (wr_cnt_q != '0);
    assign r_dec = rvalid_i & rready_i & rlast_i & (rd_cnt_q != '0);
    assign clr   = (state_q == CONV_RST) || tmo_force;

    // Outstanding counters and pending-valid tracking
    always_comb begin
        wr_cnt_d  = wr_cnt_q + CNT_W'(aw_hs) - CNT_W'(b_dec);
        rd_cnt_d  = rd_cnt_q + CNT_W'(ar_hs) - CNT_W'(r_dec);
        aw_pend_d = m_axi_awvalid & ~m_axi_awready;
        ar_pend_d = m_axi_arvalid & ~m_axi_arready;
        if (clr) begin
            wr_cnt_d  = '0;
            rd_cnt_d  = '0;
            aw_pend_d = 1'b0;
            ar_pend_d = 1'b0;
        end
    end

    // State and counter registers
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q      <= CONV_RST;
            rst_cnt_q    <= '0;
            from_drain_q <= 1'b0;
            aw_pend_q    <= 1'b0;
            ar_pend_q    <= 1'b0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            from_drain_q <= from_drain_d;
            aw_pend_q    <= aw_pend_d;
            ar_pend_q    <= ar_pend_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
        end
    end

    assign drain_ack_o      = (state_q == DONE);
    assign conv_reset_no    = (state_q != CONV_RST);
    assign wr_outstanding_o = wr_cnt_q;
    assign rd_outstanding_o = rd_cnt_q;

endmodule

// File: tb/tb_axi_clock_converter_drain_ctrl.sv
// Directed bench for axi_clock_converter_drain_ctrl.
// Drives and samples on the falling edge; DUT registers on the rising edge.
module tb_axi_clock_converter_drain_ctrl;

    localparam int MAXO = 16;
    localparam int RSTC = 8;
    localparam int TMOC = 64;
    localparam int CW = $clog2(MAXO + 1);

    logic clk = 1'b0;
    logic rst_n;
    logic s_awvalid, s_awready, m_awvalid, m_awready;
    logic s_arvalid, s_arready, m_arvalid, m_arready;
    logic bvalid, bready, rvalid, rready, rlast;
    logic drain_req, drain_ack, conv_rst_n, tmo;
    logic [CW-1:0] wr_o, rd_o;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    axi_clock_converter_drain_ctrl #(
        .MAX_OUTSTANDING(MAXO),
        .RESET_CYCLES(RSTC),
        .TIMEOUT_CYCLES(TMOC)
    ) dut (
        .clock_i(clk),
        .reset_ni(rst_n),
        .s_axi_awvalid(s_awvalid),
        .s_axi_awready(s_awready),
        .m_axi_awvalid(m_awvalid),
        .m_axi_awready(m_awready),
        .s_axi_arvalid(s_arvalid),
        .s_axi_arready(s_arready),
        .m_axi_arvalid(m_arvalid),
        .m_axi_arready(m_arready),
        .bvalid_i(bvalid),
        .bready_i(bready),
        .rvalid_i(rvalid),
        .rready_i(rready),
        .rlast_i(rlast),
        .drain_req_i(drain_req),
        .drain_ack_o(drain_ack),
        .conv_reset_no(conv_rst_n),
        .wr_outstanding_o(wr_o),
        .rd_outstanding_o(rd_o),
        .timeout_o(tmo)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        s_awvalid = 1'b1; m_awready = 1'b1;
        s_arvalid = 1'b1; m_arready = 1'b1;
        bvalid = 0; bready = 1; rvalid = 0; rready = 1; rlast = 0;
        drain_req = 0;
        step(3);
        total++; if (conv_rst_n !== 1'b0) begin bad++; $display("FAIL rst_conv got=%b exp=0", conv_rst_n); end
        total++; if (drain_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", drain_ack); end
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL rst_tmo got=%b exp=0", tmo); end
        total++; if (wr_o !== '0 || rd_o !== '0) begin bad++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", wr_o, rd_o); end
        total++; if ({s_awready, s_arready, m_awvalid, m_arvalid} !== 4'b0) begin bad++; $display("FAIL rst_gate got=%b exp=0000", {s_awready, s_arready, m_awvalid, m_arvalid}); end
        rst_n = 1'b1;
        for (int i = 1; i <= RSTC; i++) begin
            #1;
            total++; if (conv_rst_n !== 1'b0 || s_awready !== 1'b0) begin bad++; $display("FAIL rel_cyc%0d got conv=%b awr=%b exp=0,0", i, conv_rst_n, s_awready); end
            step(1);
        end
        total++; if (conv_rst_n !== 1'b1 || s_awready !== 1'b1) begin bad++; $display("FAIL rel_open got conv=%b awr=%b exp=1,1", conv_rst_n, s_awready); end
        s_awvalid = 0; s_arvalid = 0;
    endtask

    task automatic test_limit;
        s_awvalid = 1;
        step(16);
        total++; if (wr_o !== CW'(16)) begin bad++; $display("FAIL lim_cnt got=%0d exp=16", wr_o); end
        total++; if (s_awready !== 1'b0 || m_awvalid !== 1'b0) begin bad++; $display("FAIL lim_closed got awr=%b mav=%b exp=0,0", s_awready, m_awvalid); end
        bvalid = 1;
        step(1);
        bvalid = 0; #1;
        total++; if (wr_o !== CW'(15)) begin bad++; $display("FAIL lim_b got=%0d exp=15", wr_o); end
        total++; if (s_awready !== 1'b1) begin bad++; $display("FAIL lim_reopen got=%b exp=1", s_awready); end
        s_awvalid = 0;
        bvalid = 1;
        step(10);
        bvalid = 0; #1;
        total++; if (wr_o !== CW'(5)) begin bad++; $display("FAIL cnt_to5 got=%0d exp=5", wr_o); end
        s_awvalid = 1; bvalid = 1; #1;
        total++; if (m_awvalid !== 1'b1) begin bad++; $display("FAIL both_open got=%b exp=1", m_awvalid); end
        step(1);
        s_awvalid = 0; bvalid = 0; #1;
        total++; if (wr_o !== CW'(5)) begin bad++; $display("FAIL both_same got=%0d exp=5", wr_o); end
    endtask

    task automatic test_read_count;
        s_arvalid = 1;
        step(2);
        s_arvalid = 0;
        rvalid = 1; rlast = 0;
        step(3);
        total++; if (rd_o !== CW'(2)) begin bad++; $display("FAIL r_nolast got=%0d exp=2", rd_o); end
        rlast = 1;
        step(1);
        total++; if (rd_o !== CW'(1)) begin bad++; $display("FAIL r_last got=%0d exp=1", rd_o); end
        step(2);
        total++; if (rd_o !== '0) begin bad++; $display("FAIL r_sat got=%0d exp=0", rd_o); end
        rvalid = 0; rlast = 0;
        bvalid = 1;
        step(6);
        bvalid = 0;
        total++; if (wr_o !== '0) begin bad++; $display("FAIL b_sat got=%0d exp=0", wr_o); end
    endtask

    task automatic test_drain_pend;
        m_awready = 0; s_awvalid = 1; #1;
        total++; if (m_awvalid !== 1'b1 || s_awready !== 1'b0) begin bad++; $display("FAIL pend_pre got mav=%b awr=%b exp=1,0", m_awvalid, s_awready); end
        step(1);
        drain_req = 1;
        step(1);
        total++; if (m_awvalid !== 1'b1) begin bad++; $display("FAIL pend_hold got=%b exp=1", m_awvalid); end
        m_awready = 1;
        step(1);
        total++; if (wr_o !== CW'(1) || m_awvalid !== 1'b0) begin bad++; $display("FAIL pend_acc got wr=%0d mav=%b exp=1,0", wr_o, m_awvalid); end
        s_awvalid = 0;
        bvalid = 1;
        step(1);
        bvalid = 0; #1;
        total++; if (conv_rst_n !== 1'b1 || wr_o !== '0) begin bad++; $display("FAIL pend_b got conv=%b wr=%0d exp=1,0", conv_rst_n, wr_o); end
        step(1);
        total++; if (conv_rst_n !== 1'b0 || drain_ack !== 1'b0) begin bad++; $display("FAIL pend_crst got conv=%b ack=%b exp=0,0", conv_rst_n, drain_ack); end
        step(RSTC - 1);
        total++; if (drain_ack !== 1'b0 || conv_rst_n !== 1'b0) begin bad++; $display("FAIL pend_crst_end got ack=%b conv=%b exp=0,0", drain_ack, conv_rst_n); end
        step(1);
        total++; if (drain_ack !== 1'b1 || conv_rst_n !== 1'b1) begin bad++; $display("FAIL pend_done got ack=%b conv=%b exp=1,1", drain_ack, conv_rst_n); end
        s_awvalid = 1; #1;
        total++; if (s_awready !== 1'b0 || m_awvalid !== 1'b0) begin bad++; $display("FAIL done_closed got awr=%b mav=%b exp=0,0", s_awready, m_awvalid); end
        drain_req = 0;
        step(1);
        total++; if (drain_ack !== 1'b0 || s_awready !== 1'b1) begin bad++; $display("FAIL done_run got ack=%b awr=%b exp=0,1", drain_ack, s_awready); end
        s_awvalid = 0;
    endtask

    task automatic test_drain_outstanding;
        s_awvalid = 1;
        step(3);
        s_awvalid = 0; s_arvalid = 1;
        step(2);
        s_arvalid = 0; #1;
        total++; if (wr_o !== CW'(3) || rd_o !== CW'(2)) begin bad++; $display("FAIL out_cnt got=%0d/%0d exp=3/2", wr_o, rd_o); end
        drain_req = 1;
        step(1);
        s_arvalid = 1; #1;
        total++; if (m_arvalid !== 1'b0 || s_arready !== 1'b0) begin bad++; $display("FAIL out_ar_closed got mav=%b arr=%b exp=0,0", m_arvalid, s_arready); end
        s_arvalid = 0;
        bvalid = 1;
        step(3);
        bvalid = 0; rvalid = 1; rlast = 1;
        step(2);
        rvalid = 0; rlast = 0; #1;
        total++; if (drain_ack !== 1'b0 || conv_rst_n !== 1'b1 || wr_o !== '0 || rd_o !== '0) begin bad++; $display("FAIL out_resp got ack=%b conv=%b wr=%0d rd=%0d exp=0,1,0,0", drain_ack, conv_rst_n, wr_o, rd_o); end
        step(RSTC);
        total++; if (drain_ack !== 1'b0) begin bad++; $display("FAIL out_early got=%b exp=0", drain_ack); end
        step(1);
        total++; if (drain_ack !== 1'b1) begin bad++; $display("FAIL out_ack got=%b exp=1", drain_ack); end
        drain_req = 0;
        step(1);
        total++; if (drain_ack !== 1'b0 || s_arready !== 1'b1) begin bad++; $display("FAIL out_run got ack=%b arr=%b exp=0,1", drain_ack, s_arready); end
    endtask

    task automatic test_early_release;
        s_awvalid = 1;
        step(1);
        s_awvalid = 0;
        drain_req = 1;
        step(1);
        drain_req = 0;
        step(1);
        total++; if (conv_rst_n !== 1'b1 || drain_ack !== 1'b0) begin bad++; $display("FAIL er_drain got conv=%b ack=%b exp=1,0", conv_rst_n, drain_ack); end
        bvalid = 1;
        step(1);
        bvalid = 0;
        step(1 + RSTC);
        total++; if (drain_ack !== 1'b1) begin bad++; $display("FAIL er_done got=%b exp=1", drain_ack); end
        step(1);
        total++; if (drain_ack !== 1'b0 || conv_rst_n !== 1'b1) begin bad++; $display("FAIL er_run got ack=%b conv=%b exp=0,1", drain_ack, conv_rst_n); end
    endtask

`ifdef AXI_DRAIN_TIMEOUT_EN
    task automatic test_timeout;
        s_awvalid = 1;
        step(1);
        s_awvalid = 0;
        drain_req = 1;
        step(1);
        step(TMOC - 1);
        total++; if (conv_rst_n !== 1'b1 || tmo !== 1'b0) begin bad++; $display("FAIL tmo_pre got conv=%b tmo=%b exp=1,0", conv_rst_n, tmo); end
        step(1);
        total++; if (conv_rst_n !== 1'b0 || tmo !== 1'b1 || wr_o !== '0) begin bad++; $display("FAIL tmo_hit got conv=%b tmo=%b wr=%0d exp=0,1,0", conv_rst_n, tmo, wr_o); end
        step(RSTC);
        total++; if (drain_ack !== 1'b1) begin bad++; $display("FAIL tmo_done got=%b exp=1", drain_ack); end
        drain_req = 0;
        step(1);
        total++; if (tmo !== 1'b1 || drain_ack !== 1'b0) begin bad++; $display("FAIL tmo_sticky got tmo=%b ack=%b exp=1,0", tmo, drain_ack); end
    endtask
`endif

    task automatic test_reset_mid_drain;
        s_awvalid = 1; s_arvalid = 1;
        step(1);
        s_awvalid = 0; s_arvalid = 0;
        drain_req = 1;
        step(1);
        rst_n = 0;
        step(1);
        total++; if (conv_rst_n !== 1'b0 || drain_ack !== 1'b0) begin bad++; $display("FAIL mid_conv got conv=%b ack=%b exp=0,0", conv_rst_n, drain_ack); end
        total++; if (wr_o !== '0 || rd_o !== '0 || tmo !== 1'b0) begin bad++; $display("FAIL mid_clr got wr=%0d rd=%0d tmo=%b exp=0,0,0", wr_o, rd_o, tmo); end
        drain_req = 0; rst_n = 1;
        step(RSTC);
        total++; if (conv_rst_n !== 1'b1 || drain_ack !== 1'b0) begin bad++; $display("FAIL mid_run got conv=%b ack=%b exp=1,0", conv_rst_n, drain_ack); end
    endtask

    initial begin
        test_reset;
        test_limit;
        test_read_count;
        test_drain_pend;
        test_drain_outstanding;
        test_early_release;
`ifdef AXI_DRAIN_TIMEOUT_EN
        test_timeout;
`endif
        test_reset_mid_drain;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
